// File: rtl/fpga_log_fifo_pkg.sv
// Shared constants for the FPGA log FIFO: APB register map, STATUS bit layout and
// the position of the firmware's event toggle in generic_output_wires.
package fpga_log_pkg;

   localparam int       LOG_DEPTH        = 1024;
   localparam logic [3:0] LOG_DATA_OFF   = 4'h0;
   localparam logic [3:0] LOG_STATUS_OFF = 4'h4;

   localparam int STATUS_EMPTY_BIT = 0;
   localparam int STATUS_FULL_BIT  = 1;
   localparam int STATUS_OVF_BIT   = 2;
   localparam int STATUS_COUNT_LSB = 16;

   localparam int TOGGLE_BIT = 8;

   typedef enum logic [1:0] {
      REG_DATA,
      REG_STATUS,
      REG_NONE
   } logReg_e;

   // Anything outside the two mapped offsets is treated as an error access.
   function automatic logReg_e decodeReg(input logic [3:0] addr);
      case (addr)
         LOG_DATA_OFF:   return REG_DATA;
         LOG_STATUS_OFF: return REG_STATUS;
         default:        return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/fpga_log_fifo_if.sv
// APB slave bus used by the host to drain the log FIFO.
interface fpga_log_fifo_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [3:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/fpga_log_fifo_sync.sv
// Single-clock FIFO with a first-word-fall-through head; a pop frees its slot in the
// same cycle, so a push into a full FIFO is accepted when a pop happens alongside it.
module fpga_log_sync_fifo #(
   parameter int  DEPTH = 1024,
   parameter int  WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_full   = (r_count == FULL_COUNT);
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_data   = r_mem[r_rdPtr];
   assign w_doPop  = i_pop && !o_empty;
   assign w_doPush = i_push && (!o_full || w_doPop);

   // Storage carries no reset; validity is tracked entirely by the pointers and count.
   always_ff @(posedge i_clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_doPush && !w_doPop) begin
            r_count <= r_count + 1'b1;
         end else if (w_doPop && !w_doPush) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpga_log_fifo.sv
// Captures firmware log bytes on every toggle of generic_output_wires[8] and lets the
// host drain them over APB (DATA pops one entry, STATUS reports fill level/overflow).
module fpga_log_fifo
   import fpga_log_pkg::*;
#(
   parameter int DEPTH = LOG_DEPTH
) (
   input  logic           core_clk,
   input  logic           cptra_rst_b,
   input  logic [63:0]    generic_output_wires,
   fpga_log_fifo_if.slave apb
);

   localparam int AW = $clog2(DEPTH);

   logic          r_prevToggle;
   logic          r_overflow;
   logic          w_event;
   logic          w_access;
   logic          w_dataRead;
   logic          w_statusWrite;
   logic          w_pop;
   logic          w_setOvf;
   logic          w_full;
   logic          w_empty;
   logic [7:0]    w_head;
   logic [AW:0]   w_count;
   logic [31:0]   w_status;
   logReg_e       w_reg;
   logic          w_unusedBits;

   assign w_reg         = decodeReg(apb.paddr);
   assign w_access      = apb.psel && apb.penable;
   assign w_event       = generic_output_wires[TOGGLE_BIT] != r_prevToggle;
   assign w_dataRead    = w_access && !apb.pwrite && (w_reg == REG_DATA);
   assign w_statusWrite = w_access && apb.pwrite && (w_reg == REG_STATUS);
   assign w_pop         = w_dataRead && !w_empty;
   assign w_setOvf      = w_event && w_full && !w_pop;
   assign apb.pready    = 1'b1;
   assign w_unusedBits  = ^{generic_output_wires[63:9], apb.pwdata[31:3], apb.pwdata[1:0]};

   fpga_log_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .i_clk   (core_clk),
      .i_rst_n (cptra_rst_b),
      .i_push  (w_event),
      .i_data  (generic_output_wires[7:0]),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // A drop in the same cycle as a host clear keeps the overflow flag set.
   always_ff @(posedge core_clk or negedge cptra_rst_b) begin
      if (!cptra_rst_b) begin
         r_prevToggle <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_prevToggle <= generic_output_wires[TOGGLE_BIT];
         if (w_setOvf) begin
            r_overflow <= 1'b1;
         end else if (w_statusWrite && apb.pwdata[STATUS_OVF_BIT]) begin
            r_overflow <= 1'b0;
         end
      end
   end

   always_comb begin
      w_status                              = '0;
      w_status[STATUS_EMPTY_BIT]            = w_empty;
      w_status[STATUS_FULL_BIT]             = w_full;
      w_status[STATUS_OVF_BIT]              = r_overflow;
      w_status[STATUS_COUNT_LSB +: AW+1]    = w_count;
   end

   // Read data is only driven during an access phase and is forced quiet while in reset.
   always_comb begin
      apb.prdata  = '0;
      apb.pslverr = 1'b0;
      if (cptra_rst_b && w_access) begin
         case (w_reg)
            REG_DATA: begin
               if (!apb.pwrite && !w_empty) begin
                  apb.prdata = {23'b0, 1'b1, w_head};
               end
            end
            REG_STATUS: begin
               if (!apb.pwrite) begin
                  apb.prdata = w_status;
               end
            end
            default: begin
               apb.pslverr = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpga_log_fifo.sv
// Directed bench for fpga_log_fifo: a table of single APB accesses plus hand-written
// sequences for fill/overflow, pop-with-push on a full FIFO and reset behaviour.
`timescale 1ns/1ps
module tb_fpga_log_fifo;

   localparam int DEPTH = 1024;

   typedef struct {
      logic        setGen;
      logic [8:0]  gen;
      logic [3:0]  addr;
      logic        write;
      logic [31:0] wdata;
      logic [31:0] expRdata;
      logic        expErr;
   } vec_t;

   logic        core_clk = 1'b0;
   logic        cptra_rst_b;
   logic [63:0] generic_output_wires;
   int          checks   = 0;
   int          failures = 0;
   vec_t        vecs [17];

   fpga_log_fifo_if apb ();

   fpga_log_fifo #(
      .DEPTH (DEPTH)
   ) dut (
      .core_clk             (core_clk),
      .cptra_rst_b          (cptra_rst_b),
      .generic_output_wires (generic_output_wires),
      .apb                  (apb)
   );

   always #5 core_clk = ~core_clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   // Flip the toggle bit and present a new char; it is captured on the next rising edge.
   task automatic pushChar(input logic [7:0] ch);
      @(negedge core_clk);
      generic_output_wires[8]   = ~generic_output_wires[8];
      generic_output_wires[7:0] = ch;
   endtask

   // One APB transfer; optionally toggles a new char in during the access phase.
   task automatic applyStimulus(input logic [3:0] addr, input logic write, input logic [31:0] wdata,
                                input logic pushNow, input logic [7:0] ch,
                                output logic [31:0] rdata, output logic err);
      @(negedge core_clk);
      apb.psel    = 1'b1;
      apb.penable = 1'b0;
      apb.pwrite  = write;
      apb.paddr   = addr;
      apb.pwdata  = wdata;
      @(negedge core_clk);
      apb.penable = 1'b1;
      if (pushNow) begin
         generic_output_wires[8]   = ~generic_output_wires[8];
         generic_output_wires[7:0] = ch;
      end
      #1;
      rdata = apb.prdata;
      err   = apb.pslverr;
      @(posedge core_clk);
      #1;
      apb.psel    = 1'b0;
      apb.penable = 1'b0;
      apb.pwrite  = 1'b0;
   endtask

   task automatic readCheck(input string name, input logic [3:0] addr, input logic [31:0] expected);
      logic [31:0] rd;
      logic        er;
      applyStimulus(addr, 1'b0, 32'h0, 1'b0, 8'h00, rd, er);
      checkOutput(name, rd, expected);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;

      vecs[0]  = '{1'b0, 9'h000, 4'h4, 1'b0, 32'h0,        32'h0000_0001, 1'b0};
      vecs[1]  = '{1'b0, 9'h000, 4'h0, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b1, 9'h141, 4'h4, 1'b0, 32'h0,        32'h0001_0000, 1'b0};
      vecs[3]  = '{1'b1, 9'h042, 4'h4, 1'b0, 32'h0,        32'h0002_0000, 1'b0};
      vecs[4]  = '{1'b0, 9'h000, 4'h0, 1'b0, 32'h0,        32'h0000_0141, 1'b0};
      vecs[5]  = '{1'b0, 9'h000, 4'h0, 1'b0, 32'h0,        32'h0000_0142, 1'b0};
      vecs[6]  = '{1'b0, 9'h000, 4'h4, 1'b0, 32'h0,        32'h0000_0001, 1'b0};
      vecs[7]  = '{1'b0, 9'h000, 4'h0, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
      vecs[8]  = '{1'b1, 9'h143, 4'h8, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b0, 9'h000, 4'h4, 1'b0, 32'h0,        32'h0001_0000, 1'b0};
      vecs[10] = '{1'b0, 9'h000, 4'h0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[11] = '{1'b0, 9'h000, 4'h4, 1'b0, 32'h0,        32'h0001_0000, 1'b0};
      vecs[12] = '{1'b0, 9'h000, 4'h4, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[13] = '{1'b0, 9'h000, 4'hC, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
      vecs[14] = '{1'b0, 9'h000, 4'h8, 1'b1, 32'h0000_0004, 32'h0000_0000, 1'b1};
      vecs[15] = '{1'b0, 9'h000, 4'h0, 1'b0, 32'h0,        32'h0000_0143, 1'b0};
      vecs[16] = '{1'b0, 9'h000, 4'h4, 1'b0, 32'h0,        32'h0000_0001, 1'b0};

      cptra_rst_b          = 1'b0;
      generic_output_wires = {{55{1'b1}}, 9'h000};
      apb.psel             = 1'b0;
      apb.penable          = 1'b0;
      apb.pwrite           = 1'b0;
      apb.paddr            = 4'h0;
      apb.pwdata           = 32'h0;
      repeat (3) @(negedge core_clk);
      cptra_rst_b = 1'b1;
      #1;
      checkOutput("resetPready", {31'b0, apb.pready}, 32'h1);
      checkOutput("resetPrdata", apb.prdata, 32'h0);

      for (int i = 0; i < 17; i++) begin
         if (vecs[i].setGen) begin
            @(negedge core_clk);
            generic_output_wires[8:0] = vecs[i].gen;
         end
         applyStimulus(vecs[i].addr, vecs[i].write, vecs[i].wdata, 1'b0, 8'h00, rd, er);
         if (!vecs[i].write) begin
            checkOutput($sformatf("vec%0d_prdata", i), rd, vecs[i].expRdata);
         end
         checkOutput($sformatf("vec%0d_pslverr", i), {31'b0, er}, {31'b0, vecs[i].expErr});
      end

      $display("[TB] filling FIFO with DEPTH+3 chars");
      for (int i = 0; i < DEPTH + 3; i++) begin
         pushChar(8'(i));
      end
      readCheck("fullStatus", 4'h4, 32'h0400_0006);

      applyStimulus(4'h4, 1'b1, 32'h0000_0004, 1'b1, 8'h77, rd, er);
      checkOutput("clearVsSetErr", {31'b0, er}, 32'h0);
      readCheck("setWinsStatus", 4'h4, 32'h0400_0006);

      applyStimulus(4'h4, 1'b1, 32'h0000_0004, 1'b0, 8'h00, rd, er);
      readCheck("ovfClearedStatus", 4'h4, 32'h0400_0002);

      applyStimulus(4'h0, 1'b0, 32'h0, 1'b1, 8'hEE, rd, er);
      checkOutput("fullPopPushData", rd, 32'h0000_0100);
      readCheck("fullPopPushStatus", 4'h4, 32'h0400_0002);

      for (int i = 1; i < DEPTH; i++) begin
         readCheck($sformatf("drain%0d", i), 4'h0, {23'b0, 1'b1, 8'(i)});
      end
      readCheck("lastCharEE", 4'h0, 32'h0000_01EE);
      readCheck("drainedStatus", 4'h4, 32'h0000_0001);

      applyStimulus(4'h0, 1'b0, 32'h0, 1'b1, 8'h5A, rd, er);
      checkOutput("emptyPushReadData", rd, 32'h0000_0000);
      readCheck("emptyPushStatus", 4'h4, 32'h0001_0000);
      readCheck("emptyPushLanded", 4'h0, 32'h0000_015A);

      for (int i = 0; i < 5; i++) begin
         pushChar(8'h30 + 8'(i));
      end
      readCheck("fiveQueued", 4'h4, 32'h0005_0000);

      @(negedge core_clk);
      cptra_rst_b               = 1'b0;
      generic_output_wires[8:0] = 9'h000;
      apb.psel    = 1'b1;
      apb.penable = 1'b1;
      apb.pwrite  = 1'b0;
      apb.paddr   = 4'h4;
      #1;
      checkOutput("inResetPrdata", apb.prdata, 32'h0);
      checkOutput("inResetPslverr", {31'b0, apb.pslverr}, 32'h0);
      apb.psel    = 1'b0;
      apb.penable = 1'b0;
      repeat (2) @(negedge core_clk);
      cptra_rst_b = 1'b1;
      readCheck("afterResetStatus", 4'h4, 32'h0000_0001);

      @(negedge core_clk);
      cptra_rst_b               = 1'b0;
      generic_output_wires[8:0] = 9'h15A;
      repeat (2) @(negedge core_clk);
      cptra_rst_b = 1'b1;
      readCheck("highToggleAtRelease", 4'h4, 32'h0001_0000);
      readCheck("highToggleChar", 4'h0, 32'h0000_015A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
